// File: rtl/fifo_uart_tx_pkg.sv
// Shared frame constants and FSM state encoding for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

   localparam int unsigned DATA_BITS            = 8;
   localparam int unsigned WORD_BYTES           = 2;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_REQ     = 3'd1;
   localparam state_t S_CAPTURE = 3'd2;
   localparam state_t S_START   = 3'd3;
   localparam state_t S_DATA    = 3'd4;
   localparam state_t S_STOP    = 3'd5;

   // States in which the line idles high and no bit is being timed.
   function automatic logic idle_line(input state_t s);
      return (s == S_IDLE) || (s == S_REQ) || (s == S_CAPTURE);
   endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Free-running bit-period counter with a one-cycle bit_done pulse on the last cycle of each bit.
module uart_bit_timer
   import fifo_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   output logic bit_done
);

   localparam int unsigned        CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign bit_done = (cnt == LAST) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// Fetches 16-bit words from an upstream FIFO and sends them as two 8N1 UART frames, low byte first.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        f_empty,
   input  logic [15:0] rd_data,
   input  logic        tx_enable,
   output logic        rd_enb,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned        BIT_W     = $clog2(DATA_BITS);
   localparam int unsigned        BYTE_W    = $clog2(WORD_BYTES);
   localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(DATA_BITS - 1);
   localparam logic [BYTE_W-1:0]  LAST_BYTE = BYTE_W'(WORD_BYTES - 1);

   state_t                state, state_next;
   logic [15:0]           word_q, word_next;
   logic [BYTE_W-1:0]     byte_idx, byte_next;
   logic [BIT_W-1:0]      bit_idx, bit_next;
   logic [DATA_BITS-1:0]  byte_sel;
   logic                  tx_next;
   logic                  bit_done;
   logic                  timer_clear;

   assign timer_clear = idle_line(state);

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk      (clk),
      .resetn   (resetn),
      .clear    (timer_clear),
      .bit_done (bit_done)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      word_next  = word_q;
      byte_next  = byte_idx;
      bit_next   = bit_idx;
      case (state)
         S_IDLE:    if (tx_enable && !f_empty) state_next = S_REQ;
         S_REQ:     state_next = S_CAPTURE;
         S_CAPTURE: begin
            word_next  = rd_data;
            byte_next  = '0;
            state_next = S_START;
         end
         S_START: begin
            bit_next = '0;
            if (bit_done) state_next = S_DATA;
         end
         S_DATA: begin
            if (bit_done) begin
               bit_next = bit_idx + BIT_W'(1);
               if (bit_idx == LAST_BIT) state_next = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_done) begin
               if (byte_idx == LAST_BYTE) begin
                  state_next = S_IDLE;
               end else begin
                  byte_next  = byte_idx + BYTE_W'(1);
                  state_next = S_START;
               end
            end
         end
         default:   state_next = S_IDLE;
      endcase

      // tx is computed from the upcoming state so the registered line lines up with it.
      byte_sel = word_next[DATA_BITS*byte_next +: DATA_BITS];
      case (state_next)
         S_START: tx_next = 1'b0;
         S_DATA:  tx_next = byte_sel[bit_next];
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= S_IDLE;
         word_q   <= '0;
         byte_idx <= '0;
         bit_idx  <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_next;
         word_q   <= word_next;
         byte_idx <= byte_next;
         bit_idx  <= bit_next;
         tx       <= tx_next;
      end
   end

   assign rd_enb = (state == S_REQ);
   assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: cycle-level word-transaction model for CLKS_PER_BIT=4, UART receiver model for CLKS_PER_BIT=2.
module tb_fifo_uart_tx;

   localparam int C        = 4;
   localparam int C2       = 2;
   localparam int WORD_CYC = 2 + 20*C;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn, f_empty, tx_enable, rd_enb, tx, busy;
   logic [15:0] rd_data;
   logic        f_empty2, tx_enable2, rd_enb2, tx2, busy2;
   logic [15:0] rd_data2;

   fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .resetn(resetn), .f_empty(f_empty), .rd_data(rd_data),
      .tx_enable(tx_enable), .rd_enb(rd_enb), .tx(tx), .busy(busy)
   );

   fifo_uart_tx #(.CLKS_PER_BIT(C2)) dut2 (
      .clk(clk), .resetn(resetn), .f_empty(f_empty2), .rd_data(rd_data2),
      .tx_enable(tx_enable2), .rd_enb(rd_enb2), .tx(tx2), .busy(busy2)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Bit k (0..19) of the two-frame line sequence for a word: start, 8 data LSB first, stop.
   function automatic logic frame_bit(input logic [15:0] w, input int k);
      int b, j;
      b = k / 10;
      j = k % 10;
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return w[b*8 + j - 1];
   endfunction

   // Stimulus intent and environment FIFOs
   logic        resetn_s, tx_enable_s, tx_enable2_s;
   logic [15:0] fifo_q[$];
   logic [15:0] fifo2_q[$];
   logic        rd_prev, rd2_prev;

   // Model: pos = -1 idle, 0 read request, 1 capture, 2.. line bits of the word
   int          pos;
   logic [15:0] m_word;
   bit          m_known;

   // Statistics
   int   cyc;
   int   rd_cnt, busy_cnt, rd2_cnt, rd2_cyc;
   int   rd_cycles[$];
   int   low_cycles[$];
   bit   pend;
   logic tx_hist[8192];

   // Receiver for the CLKS_PER_BIT=2 instance
   int   rx_cnt;
   bit   rx_done;
   int   rx_low_cyc;
   logic rx_s[40];
   logic tx2_prev;

   task automatic tick();
      logic e_rd, e_tx, e_busy, rd_now, rd2_now;
      @(negedge clk);
      cyc++;
      if (m_known) begin
         e_rd   = (pos == 0);
         e_busy = (pos >= 0);
         e_tx   = (pos >= 2) ? frame_bit(m_word, (pos - 2) / C) : 1'b1;
         check($sformatf("rd_enb@%0d", cyc), {31'd0, rd_enb}, {31'd0, e_rd});
         check($sformatf("busy@%0d", cyc),   {31'd0, busy},   {31'd0, e_busy});
         check($sformatf("tx@%0d", cyc),     {31'd0, tx},     {31'd0, e_tx});
      end

      rd_now = rd_enb;
      if (rd_now === 1'b1) begin
         rd_cnt++;
         rd_cycles.push_back(cyc);
         pend = 1'b1;
      end else if (pend && tx === 1'b0) begin
         low_cycles.push_back(cyc);
         pend = 1'b0;
      end
      if (busy === 1'b1) busy_cnt++;
      if (cyc < 8192) tx_hist[cyc] = tx;

      rd2_now = rd_enb2;
      if (rd2_now === 1'b1) begin
         rd2_cnt++;
         rd2_cyc = cyc;
      end
      if (rx_cnt >= 0) begin
         rx_s[rx_cnt] = tx2;
         rx_cnt++;
         if (rx_cnt == 40) begin
            rx_cnt  = -1;
            rx_done = 1'b1;
         end
      end else if (!rx_done && tx2 === 1'b0 && tx2_prev === 1'b1) begin
         rx_s[0]    = tx2;
         rx_cnt     = 1;
         rx_low_cyc = cyc;
      end
      tx2_prev = tx2;

      // Inputs for this cycle; read data appears the cycle after a read request.
      resetn     = resetn_s;
      tx_enable  = tx_enable_s;
      tx_enable2 = tx_enable2_s;
      if (rd_prev === 1'b1 && fifo_q.size() > 0) rd_data = fifo_q.pop_front();
      else                                       rd_data = 16'($urandom);
      if (rd2_prev === 1'b1 && fifo2_q.size() > 0) rd_data2 = fifo2_q.pop_front();
      else                                         rd_data2 = 16'($urandom);
      f_empty  = (fifo_q.size() == 0);
      f_empty2 = (fifo2_q.size() == 0);
      rd_prev  = rd_now;
      rd2_prev = rd2_now;

      if (!resetn_s) begin
         m_known = 1'b1;
         pos     = -1;
      end else if (pos == -1) begin
         if (tx_enable_s && !f_empty) pos = 0;
      end else if (pos == 1) begin
         m_word = rd_data;
         pos    = 2;
      end else begin
         pos = (pos == 1 + 20*C) ? -1 : pos + 1;
      end
   endtask

   task automatic clear_stats();
      rd_cnt   = 0;
      busy_cnt = 0;
      rd_cycles.delete();
      low_cycles.delete();
      pend = 1'b0;
   endtask

   task automatic wait_rd(input int target, input int max_cyc, input string name);
      for (int i = 0; i < max_cyc && rd_cnt < target; i++) tick();
      check(name, rd_cnt, target);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   logic [19:0] a55a_bits;
   logic [15:0] rx_word;

   initial begin
      resetn = 1'b0; tx_enable = 1'b0; tx_enable2 = 1'b0;
      f_empty = 1'b1; f_empty2 = 1'b1; rd_data = '0; rd_data2 = '0;
      resetn_s = 1'b0; tx_enable_s = 1'b0; tx_enable2_s = 1'b1;
      rd_prev = 1'b0; rd2_prev = 1'b0;
      pos = -1; m_word = '0; m_known = 1'b0; cyc = 0;
      rd2_cnt = 0; rd2_cyc = 0; rx_cnt = -1; rx_done = 1'b0; rx_low_cyc = 0; tx2_prev = 1'bx;
      clear_stats();

      // Reset state
      run(3);
      check("reset_tx",      {31'd0, tx},     32'd1);
      check("reset_busy",    {31'd0, busy},   32'd0);
      check("reset_rd_enb",  {31'd0, rd_enb}, 32'd0);
      check("reset_tx2",     {31'd0, tx2},    32'd1);
      check("reset_busy2",   {31'd0, busy2},  32'd0);
      resetn_s = 1'b1;

      // Hand-derived line sequence for 0xA55A pins the model's frame builder
      a55a_bits = 20'b0010110101_0101001011;
      for (int k = 0; k < 20; k++)
         check($sformatf("model_a55a_bit%0d", k), {31'd0, frame_bit(16'hA55A, k)}, {31'd0, a55a_bits[19-k]});

      // Single word
      clear_stats();
      fifo_q.push_back(16'hA55A);
      tx_enable_s = 1'b1;
      run(WORD_CYC + 20);
      check("single_rd_pulses", rd_cnt, 1);
      check("single_busy_cycles", busy_cnt, 82);
      check("single_latency", low_cycles.size() > 0 ? low_cycles[0] - rd_cycles[0] : -1, 2);
      if (low_cycles.size() > 0)
         for (int k = 0; k < 20; k++)
            check($sformatf("single_line_bit%0d", k),
                  {31'd0, tx_hist[low_cycles[0] + k*C + C/2]}, {31'd0, a55a_bits[19-k]});

      // Empty source
      clear_stats();
      run(100);
      check("empty_rd_pulses", rd_cnt, 0);
      check("empty_busy_cycles", busy_cnt, 0);

      // Back-to-back
      clear_stats();
      fifo_q.push_back(16'h0001);
      fifo_q.push_back(16'hFFFF);
      run(2*WORD_CYC + 20);
      check("b2b_rd_pulses", rd_cnt, 2);
      check("b2b_low_count", low_cycles.size(), 2);
      if (rd_cycles.size() == 2 && low_cycles.size() == 2) begin
         check("b2b_rd_spacing", rd_cycles[1] - rd_cycles[0], 83);
         check("b2b_idle_gap", low_cycles[1] - (low_cycles[0] + 20*C - 1) - 1, 3);
      end

      // Enable drop during first data bit
      clear_stats();
      fifo_q.push_back(16'h1234);
      fifo_q.push_back(16'hBEEF);
      wait_rd(1, 10, "drop_first_rd");
      run(C + 2);
      tx_enable_s = 1'b0;
      run(WORD_CYC + 40);
      check("drop_rd_pulses", rd_cnt, 1);
      check("drop_busy_cycles", busy_cnt, WORD_CYC);
      check("drop_fifo_left", fifo_q.size(), 1);

      // Reset during data bit 3
      clear_stats();
      fifo_q.push_back(16'h5555);
      tx_enable_s = 1'b1;
      wait_rd(1, 10, "rst_first_rd");
      run(4*C + 2);
      resetn_s = 1'b0;
      tick();
      resetn_s = 1'b1;
      tick();
      check("rst_tx_after",   {31'd0, tx},   32'd1);
      check("rst_busy_after", {31'd0, busy}, 32'd0);
      check("rst_fifo_left",  fifo_q.size(), 1);
      wait_rd(2, 10, "rst_second_rd");
      run(WORD_CYC + 10);
      check("rst_low_count", low_cycles.size(), 2);
      if (low_cycles.size() == 2)
         check("rst_restart_latency", low_cycles[1] - rd_cycles[1], 2);
      check("rst_fifo_drained", fifo_q.size(), 0);

      // Bit-timing boundary with CLKS_PER_BIT=2
      check("c2_idle_rd_pulses", rd2_cnt, 0);
      fifo2_q.push_back(16'h8001);
      for (int i = 0; i < 100 && !rx_done; i++) tick();
      check("c2_rx_done", {31'd0, rx_done}, 32'd1);
      tick();
      check("c2_tx_after", {31'd0, tx2},   32'd1);
      check("c2_busy_after", {31'd0, busy2}, 32'd0);
      check("c2_rd_pulses", rd2_cnt, 1);
      check("c2_latency", rx_low_cyc - rd2_cyc, 2);
      for (int k = 0; k < 40; k++)
         check($sformatf("c2_sample%0d", k), {31'd0, rx_s[k]}, {31'd0, frame_bit(16'h8001, k / 2)});
      rx_word = '0;
      for (int b = 0; b < 2; b++) begin
         check($sformatf("c2_start%0d", b), {31'd0, rx_s[2*(b*10)+1]}, 32'd0);
         check($sformatf("c2_stop%0d", b),  {31'd0, rx_s[2*(b*10+9)+1]}, 32'd1);
         for (int i = 0; i < 8; i++) rx_word[b*8 + i] = rx_s[2*(b*10 + 1 + i) + 1];
      end
      check("c2_rx_word", {16'd0, rx_word}, 32'h8001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
